fetch_pc_queue: RTL and testbench

- Fetch-side front end for the NPC core: owns the program counter and drives the instruction ROM's address/chip-enable pair.
- Captures each combinationally returned 32-bit instruction, with its PC, into a small FIFO that feeds decode through a valid/ready handshake.
- Handles control-flow redirects from execute (flush and re-steer), halt requests, and misaligned-target detection.

---
 rtl/fetch_pc_queue.sv | 126 ++++++++++++
 tb/tb_fetch_pc_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch front end: owns the PC, drives the instruction ROM, and buffers
// {pc, inst} pairs in a small FIFO that feeds decode over valid/ready.
module fetch_pc_queue #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] inst_address,
  output logic        ce,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        fetch_misaligned,
  output logic        halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              misaligned_q, misaligned_d;
  entry_t            mem_q [DEPTH];

  logic              redirect_act;
  logic              fetch_en;
  logic              deq;

  // Halted state ignores redirects entirely.
  assign redirect_act = redirect_valid && (state_q != ST_HALTED);
  assign fetch_en     = (state_q == ST_RUN) && !halt_req && !redirect_valid &&
                        ((count_q < CNT_W'(DEPTH)) || out_ready);
  assign deq          = out_valid && out_ready;

  assign inst_address     = pc_q;
  assign ce               = fetch_en;
  assign out_valid        = (count_q != '0);
  assign out_inst         = out_valid ? mem_q[rd_ptr_q].inst : 32'h0;
  assign out_pc           = out_valid ? mem_q[rd_ptr_q].pc : 64'h0;
  assign fetch_misaligned = misaligned_q;
  assign halted           = (state_q == ST_HALTED);

  // Next-state: redirect flush takes priority over fetch/dequeue and halt.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    misaligned_d = misaligned_q;

    if (redirect_act) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (redirect_target[1:0] == 2'b00) begin
        pc_d    = redirect_target;
        state_d = ST_RUN;
      end else begin
        misaligned_d = 1'b1;
        state_d      = ST_HALTED;
      end
    end else begin
      if (fetch_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + 64'd4;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(fetch_en) - CNT_W'(deq);
      unique case (state_q)
        ST_IDLE:   state_d = ST_RUN;
        ST_RUN:    if (halt_req) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero.
  always_ff @(posedge clock) begin
    if (fetch_en) begin
      mem_q[wr_ptr_q] <= '{pc: pc_q, inst: inst};
    end
  end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue; the ROM returns inst = inst_address[31:0].
module tb_fetch_pc_queue;

  logic        clock;
  logic        reset;
  logic [63:0] inst_address;
  logic        ce;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        fetch_misaligned;
  logic        halted;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  fetch_pc_queue #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .inst_address(inst_address), .ce(ce),
    .inst(inst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .fetch_misaligned(fetch_misaligned),
    .halted(halted)
  );

  assign inst = inst_address[31:0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in IDLE (first cycle after release), inputs quiet.
  task automatic apply_reset(input logic rdy);
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 64'h0;
    halt_req = 1'b0; out_ready = rdy;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 64'h0;
    halt_req = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %0h exp 0", ce); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
    checks++; if (inst_address !== RST_PC) begin errors++; $display("FAIL rst_addr got %0h exp %0h", inst_address, RST_PC); end
    checks++; if (out_pc !== 64'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL rst_out_data got %0h/%0h exp 0/0", out_pc, out_inst); end
    checks++; if (halted !== 1'b0 || fetch_misaligned !== 1'b0) begin errors++; $display("FAIL rst_flags got %0h/%0h exp 0/0", halted, fetch_misaligned); end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL stream_idle_ce got %0h exp 0", ce); end
    tick();
    checks++; if (ce !== 1'b1 || inst_address !== RST_PC) begin errors++; $display("FAIL stream_first_fetch got ce=%0h addr=%0h exp ce=1 addr=%0h", ce, inst_address, RST_PC); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== RST_PC + 64'(4*k) || out_inst !== 32'h8000_0000 + 32'(4*k)) begin
        errors++;
        $display("FAIL stream_head_%0d got v=%0h pc=%0h inst=%0h exp v=1 pc=%0h", k, out_valid, out_pc, out_inst, RST_PC + 64'(4*k));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    tick(); tick(); tick();
    checks++; if (ce !== 1'b0 || inst_address !== 64'h8000_0008) begin errors++; $display("FAIL bp_full_stall got ce=%0h addr=%0h exp ce=0 addr=80000008", ce, inst_address); end
    tick();
    checks++; if (inst_address !== 64'h8000_0008 || out_pc !== RST_PC) begin errors++; $display("FAIL bp_frozen got addr=%0h head=%0h exp 80000008/80000000", inst_address, out_pc); end
    out_ready = 1'b1;
    #1;
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL bp_full_ce got %0h exp 1", ce); end
    tick();
    checks++; if (out_pc !== 64'h8000_0004 || inst_address !== 64'h8000_000C) begin errors++; $display("FAIL bp_swap got head=%0h addr=%0h exp 80000004/8000000c", out_pc, inst_address); end
    tick();
    checks++; if (out_pc !== 64'h8000_0008) begin errors++; $display("FAIL bp_third got %0h exp 80000008", out_pc); end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_target = 64'h8000_0100; out_ready = 1'b1;
    #1;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL redir_ce got %0h exp 0", ce); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || inst_address !== 64'h8000_0100) begin errors++; $display("FAIL redir_flush got v=%0h addr=%0h exp 0/80000100", out_valid, inst_address); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100) begin errors++; $display("FAIL redir_head got v=%0h pc=%0h exp 1/80000100", out_valid, out_pc); end
  endtask

  // Continues from test_redirect: pc is 0x8000_0104 here.
  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 64'h8000_0102;
    #1;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL mis_ce got %0h exp 0", ce); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (fetch_misaligned !== 1'b1 || halted !== 1'b1 || ce !== 1'b0) begin errors++; $display("FAIL mis_halt got mis=%0h h=%0h ce=%0h exp 1/1/0", fetch_misaligned, halted, ce); end
    checks++; if (inst_address !== 64'h8000_0104 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_pc got addr=%0h v=%0h exp 80000104/0", inst_address, out_valid); end
    redirect_valid = 1'b1; redirect_target = RST_PC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (inst_address !== 64'h8000_0104 || halted !== 1'b1 || ce !== 1'b0) begin errors++; $display("FAIL mis_ignore got addr=%0h h=%0h ce=%0h exp 80000104/1/0", inst_address, halted, ce); end
  endtask

  task automatic test_halt();
    apply_reset(1'b0);
    tick();
    tick();
    halt_req = 1'b1;
    #1;
    checks++; if (ce !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL halt_ce got ce=%0h v=%0h exp 0/1", ce, out_valid); end
    tick();
    halt_req = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || ce !== 1'b0 || out_pc !== RST_PC || inst_address !== 64'h8000_0004) begin errors++; $display("FAIL halt_state got h=%0h ce=%0h head=%0h addr=%0h exp 1/0/80000000/80000004", halted, ce, out_pc, inst_address); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL halt_drain got v=%0h pc=%0h inst=%0h exp 0/0/0", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (ce !== 1'b1 || inst_address !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_start got ce=%0h addr=%0h exp 1/fffffffffffffffc", ce, inst_address); end
    tick();
    checks++; if (inst_address !== 64'h0 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_inst !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rollover got addr=%0h head=%0h inst=%0h exp 0/fffffffffffffffc/fffffffc", inst_address, out_pc, out_inst); end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b1 || inst_address !== 64'h8000_0008) begin errors++; $display("FAIL midrst_pre got v=%0h addr=%0h exp 1/80000008", out_valid, inst_address); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || ce !== 1'b0 || inst_address !== RST_PC || fetch_misaligned !== 1'b0) begin errors++; $display("FAIL midrst_clear got v=%0h ce=%0h addr=%0h mis=%0h exp 0/0/80000000/0", out_valid, ce, inst_address, fetch_misaligned); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
